// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// default word size and the address field width helpers.
package icache_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  // Word-offset field width within a line.
  function automatic int offset_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // Line-index field width.
  function automatic int index_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag is whatever is left of the address above offset and index.
  function automatic int tag_width(input int word_size, input int line_words,
                                   input int num_lines);
    return word_size - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side bus of the instruction cache, plus the
// performance counters. The cache is the slave; the CPU/memory environment
// is the master.
interface icache_if #(
  parameter int WORD_SIZE  = icache_pkg::WORD_SIZE,
  parameter int LINE_WORDS = 4
);

  logic                            cpu_read;
  logic [WORD_SIZE-1:0]            cpu_addr;
  logic [WORD_SIZE-1:0]            cpu_rdata;
  logic                            cpu_ready;
  logic                            flush;
  logic                            mem_read;
  logic [WORD_SIZE-1:0]            mem_addr;
  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata;
  logic                            mem_valid;
  logic [WORD_SIZE-1:0]            hit_count;
  logic [WORD_SIZE-1:0]            miss_count;

  modport slave (
    input  cpu_read, cpu_addr, flush, mem_rdata, mem_valid,
    output cpu_rdata, cpu_ready, mem_read, mem_addr, hit_count, miss_count
  );

  modport master (
    output cpu_read, cpu_addr, flush, mem_rdata, mem_valid,
    input  cpu_rdata, cpu_ready, mem_read, mem_addr, hit_count, miss_count
  );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage for the cache: one combinational read port, one
// synchronous line write port and a synchronous clear of every valid bit.
module icache_array #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 11
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear_all,
  input  logic [IDX_W-1:0]                rd_index,
  output logic                            rd_valid,
  output logic [TAG_W-1:0]                rd_tag,
  output logic [WORD_SIZE*LINE_WORDS-1:0] rd_line,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_index,
  input  logic [TAG_W-1:0]                wr_tag,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] wr_line
);

  logic [NUM_LINES-1:0]            valid_q;
  logic [TAG_W-1:0]                tag_q  [NUM_LINES];
  logic [WORD_SIZE*LINE_WORDS-1:0] data_q [NUM_LINES];

  // Valid bits: a clear wins over a fill landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: hit lookup and word select,
// two-state miss FSM that fetches a whole line, and hit/miss counters.
module icache #(
  parameter int WORD_SIZE  = icache_pkg::WORD_SIZE,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8
) (
  input logic      clk,
  input logic      reset,
  icache_if.slave  bus
);

  import icache_pkg::*;

  localparam int OFF_W = offset_width(LINE_WORDS);
  localparam int IDX_W = index_width(NUM_LINES);
  localparam int TAG_W = tag_width(WORD_SIZE, LINE_WORDS, NUM_LINES);

  state_t                          state_q, state_d;
  logic [WORD_SIZE-1:0]            line_addr_q;
  logic [WORD_SIZE-1:0]            hit_q, miss_q;

  logic [OFF_W-1:0]                req_off;
  logic [IDX_W-1:0]                req_idx;
  logic [TAG_W-1:0]                req_tag;
  logic                            rd_valid;
  logic [TAG_W-1:0]                rd_tag;
  logic [WORD_SIZE*LINE_WORDS-1:0] rd_line;
  logic                            hit;
  logic                            miss;
  logic                            fill;

  assign req_off = bus.cpu_addr[OFF_W-1:0];
  assign req_idx = bus.cpu_addr[OFF_W +: IDX_W];
  assign req_tag = bus.cpu_addr[WORD_SIZE-1 -: TAG_W];

  icache_array #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .clear_all(bus.flush),
    .rd_index (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill),
    .wr_index (line_addr_q[OFF_W +: IDX_W]),
    .wr_tag   (line_addr_q[WORD_SIZE-1 -: TAG_W]),
    .wr_line  (bus.mem_rdata)
  );

  // Next state plus all handshake outputs; the hit path only ever reads the
  // array, never mem_rdata, so a fill is visible one cycle later at best.
  always_comb begin
    state_d       = state_q;
    hit           = 1'b0;
    miss          = 1'b0;
    fill          = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_read  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_read) begin
          if (rd_valid && (rd_tag == req_tag)) begin
            hit           = 1'b1;
            bus.cpu_ready = 1'b1;
            bus.cpu_rdata = rd_line[int'(req_off)*WORD_SIZE +: WORD_SIZE];
          end else begin
            miss    = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_valid) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched line address and wrapping performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q <= state_d;
      if (hit) begin
        hit_q <= hit_q + 1'b1;
      end
      if (miss) begin
        miss_q      <= miss_q + 1'b1;
        line_addr_q <= {bus.cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
      end
    end
  end

  assign bus.mem_addr   = line_addr_q;
  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache with a latency-3 line memory driven from
// tasks. Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_icache;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  icache_if #(.WORD_SIZE(16), .LINE_WORDS(4)) bus ();

  icache #(
    .WORD_SIZE (16),
    .LINE_WORDS(4),
    .NUM_LINES (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word holds its own address XOR 0xA000.
  function automatic logic [63:0] mem_line(input logic [15:0] base);
    logic [63:0] l;
    for (int i = 0; i < 4; i++) begin
      l[i*16 +: 16] = 16'hA000 ^ (base + 16'(i));
    end
    return l;
  endfunction

  // Serve one line fill, entered in the first FETCH cycle; mem_valid is
  // pulsed on the third FETCH cycle and the task returns in the IDLE cycle.
  task automatic serve_line(input logic [15:0] base, input logic flush_at_fill);
    int waited;
    waited = 0;
    while (bus.mem_read !== 1'b1 && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (bus.mem_read !== 1'b1) $display("[TB] FAIL fill_start: mem_read=%b required 1", bus.mem_read);
    else passed++;
    checks++;
    if (bus.mem_addr !== base) $display("[TB] FAIL fill_addr: mem_addr=%h required %h", bus.mem_addr, base);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    bus.mem_rdata = mem_line(base);
    bus.mem_valid = 1'b1;
    bus.flush     = flush_at_fill;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0) $display("[TB] FAIL fetch_stall: cpu_ready=%b required 0", bus.cpu_ready);
    else passed++;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_rdata = {4{16'hDEAD}};
    #1;
    checks++;
    if (bus.mem_read !== 1'b0) $display("[TB] FAIL fill_done: mem_read=%b required 0", bus.mem_read);
    else passed++;
  endtask

  task automatic test_reset();
    bus.cpu_read  = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.flush     = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = {4{16'hDEAD}};
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b required 0", bus.cpu_ready);
    else passed++;
    checks++;
    if (bus.cpu_rdata !== 16'h0000) $display("[TB] FAIL reset_rdata: got %h required 0000", bus.cpu_rdata);
    else passed++;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0000)
      $display("[TB] FAIL reset_mem: mem_read=%b mem_addr=%h required 0/0000", bus.mem_read, bus.mem_addr);
    else passed++;
    checks++;
    if (bus.hit_count !== 16'h0000 || bus.miss_count !== 16'h0000)
      $display("[TB] FAIL reset_counts: hit=%h miss=%h required 0/0", bus.hit_count, bus.miss_count);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_cold_miss();
    @(negedge clk);
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 16'h0012;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0 || bus.mem_read !== 1'b0)
      $display("[TB] FAIL cold_miss_t: ready=%b mem_read=%b required 0/0", bus.cpu_ready, bus.mem_read);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0010)
      $display("[TB] FAIL cold_miss_t1: mem_read=%b mem_addr=%h required 1/0010", bus.mem_read, bus.mem_addr);
    else passed++;
    serve_line(16'h0010, 1'b0);
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'hA012)
      $display("[TB] FAIL cold_miss_hit: ready=%b rdata=%h required 1/A012", bus.cpu_ready, bus.cpu_rdata);
    else passed++;
    checks++;
    if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0)
      $display("[TB] FAIL cold_miss_counts: miss=%0d hit=%0d required 1/0", bus.miss_count, bus.hit_count);
    else passed++;
  endtask

  task automatic test_spatial_hits();
    logic [15:0] addrs [3];
    logic [15:0] words [3];
    addrs = '{16'h0010, 16'h0011, 16'h0013};
    words = '{16'hA010, 16'hA011, 16'hA013};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.cpu_addr = addrs[k];
      #1;
      checks++;
      if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== words[k] || bus.mem_read !== 1'b0)
        $display("[TB] FAIL spatial_hit%0d: ready=%b rdata=%h mem_read=%b required 1/%h/0",
                 k, bus.cpu_ready, bus.cpu_rdata, bus.mem_read, words[k]);
      else passed++;
      checks++;
      if (bus.hit_count !== 16'(k + 1))
        $display("[TB] FAIL spatial_count%0d: hit=%0d required %0d", k, bus.hit_count, k + 1);
      else passed++;
    end
    @(negedge clk);
    bus.cpu_read = 1'b0;
    #1;
    checks++;
    if (bus.hit_count !== 16'd4) $display("[TB] FAIL spatial_total: hit=%0d required 4", bus.hit_count);
    else passed++;
  endtask

  task automatic test_conflict();
    logic [15:0] seq   [3];
    logic [15:0] words [3];
    seq   = '{16'h0020, 16'h0000, 16'h0020};
    words = '{16'hA020, 16'hA000, 16'hA020};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.cpu_read = 1'b1;
      bus.cpu_addr = seq[k];
      #1;
      checks++;
      if (bus.cpu_ready !== 1'b0) $display("[TB] FAIL conflict_miss%0d: ready=%b required 0", k, bus.cpu_ready);
      else passed++;
      @(negedge clk);
      #1;
      serve_line(seq[k], 1'b0);
      checks++;
      if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== words[k])
        $display("[TB] FAIL conflict_data%0d: ready=%b rdata=%h required 1/%h", k, bus.cpu_ready, bus.cpu_rdata, words[k]);
      else passed++;
      checks++;
      if (bus.miss_count !== 16'(k + 2))
        $display("[TB] FAIL conflict_count%0d: miss=%0d required %0d", k, bus.miss_count, k + 2);
      else passed++;
    end
    @(negedge clk);
    bus.cpu_read = 1'b0;
    #1;
    checks++;
    if (bus.hit_count !== 16'd7) $display("[TB] FAIL conflict_hits: hit=%0d required 7", bus.hit_count);
    else passed++;
  endtask

  task automatic test_addr_change();
    @(negedge clk);
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 16'h0040;
    @(negedge clk);
    bus.cpu_addr = 16'h0010;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0 || bus.mem_addr !== 16'h0040)
      $display("[TB] FAIL change_fetch: ready=%b mem_addr=%h required 0/0040", bus.cpu_ready, bus.mem_addr);
    else passed++;
    serve_line(16'h0040, 1'b0);
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'hA010)
      $display("[TB] FAIL change_newaddr: ready=%b rdata=%h required 1/A010", bus.cpu_ready, bus.cpu_rdata);
    else passed++;
    @(negedge clk);
    bus.cpu_addr = 16'h0041;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'hA041 || bus.mem_read !== 1'b0)
      $display("[TB] FAIL change_filled: ready=%b rdata=%h mem_read=%b required 1/A041/0",
               bus.cpu_ready, bus.cpu_rdata, bus.mem_read);
    else passed++;
    @(negedge clk);
    bus.cpu_read = 1'b0;
    #1;
    checks++;
    if (bus.miss_count !== 16'd5 || bus.hit_count !== 16'd9)
      $display("[TB] FAIL change_counts: miss=%0d hit=%0d required 5/9", bus.miss_count, bus.hit_count);
    else passed++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 16'h0050;
    @(negedge clk);
    #1;
    serve_line(16'h0050, 1'b1);
    checks++;
    if (bus.cpu_ready !== 1'b0) $display("[TB] FAIL flush_fill_invalid: ready=%b required 0", bus.cpu_ready);
    else passed++;
    @(negedge clk);
    #1;
    serve_line(16'h0050, 1'b0);
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'hA050 || bus.miss_count !== 16'd7)
      $display("[TB] FAIL flush_refill: ready=%b rdata=%h miss=%0d required 1/A050/7",
               bus.cpu_ready, bus.cpu_rdata, bus.miss_count);
    else passed++;
    @(negedge clk);
    bus.cpu_addr = 16'h0041;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0) $display("[TB] FAIL flush_all_lines: ready=%b required 0", bus.cpu_ready);
    else passed++;
    @(negedge clk);
    #1;
    serve_line(16'h0040, 1'b0);
    @(negedge clk);
    bus.cpu_addr = 16'h0042;
    bus.flush    = 1'b1;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'hA042)
      $display("[TB] FAIL flush_idle_hit: ready=%b rdata=%h required 1/A042", bus.cpu_ready, bus.cpu_rdata);
    else passed++;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0) $display("[TB] FAIL flush_idle_after: ready=%b required 0", bus.cpu_ready);
    else passed++;
    @(negedge clk);
    #1;
    serve_line(16'h0040, 1'b0);
    checks++;
    if (bus.miss_count !== 16'd9) $display("[TB] FAIL flush_counts: miss=%0d required 9", bus.miss_count);
    else passed++;
    @(negedge clk);
    bus.cpu_read = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 16'h0060;
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_read !== 1'b1) $display("[TB] FAIL rst_fetch_start: mem_read=%b required 1", bus.mem_read);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.cpu_ready !== 1'b0)
      $display("[TB] FAIL rst_async: mem_read=%b mem_addr=%h ready=%b required 0/0000/0",
               bus.mem_read, bus.mem_addr, bus.cpu_ready);
    else passed++;
    checks++;
    if (bus.hit_count !== 16'd0 || bus.miss_count !== 16'd0)
      $display("[TB] FAIL rst_counts: hit=%0d miss=%0d required 0/0", bus.hit_count, bus.miss_count);
    else passed++;
    @(negedge clk);
    reset        = 1'b0;
    bus.cpu_read = 1'b0;
    @(negedge clk);
    bus.mem_rdata = mem_line(16'h0000);
    bus.mem_valid = 1'b1;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_rdata = {4{16'hDEAD}};
    #1;
    checks++;
    if (bus.mem_read !== 1'b0) $display("[TB] FAIL rst_stray_valid: mem_read=%b required 0", bus.mem_read);
    else passed++;
    @(negedge clk);
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 16'h0000;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0) $display("[TB] FAIL rst_stray_ignored: ready=%b required 0", bus.cpu_ready);
    else passed++;
    @(negedge clk);
    #1;
    serve_line(16'h0000, 1'b0);
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 16'hA000 || bus.miss_count !== 16'd1)
      $display("[TB] FAIL rst_refill: ready=%b rdata=%h miss=%0d required 1/A000/1",
               bus.cpu_ready, bus.cpu_rdata, bus.miss_count);
    else passed++;
    @(negedge clk);
    bus.cpu_read = 1'b0;
  endtask

  // Scenario sequence and summary.
  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_cold_miss();
    test_spatial_hits();
    test_conflict();
    test_addr_change();
    test_flush();
    test_reset_mid_fetch();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard time limit so a stuck scenario still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, %0d/%0d passed so far", passed, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined CPU's instruction-fetch port and the backing instruction memory. Hits return the instruction word combinationally in the request cycle. Misses stall the CPU through `cpu_ready` while a full line is fetched from memory, which responds after a variable number of cycles. Hit and miss counters are exposed for performance reporting alongside `num_inst`.

## Interface
Parameters:
- `WORD_SIZE`, 16: address and data width; addresses are word-addressed.
- `LINE_WORDS`, 4: words per line; must be a power of two.
- `NUM_LINES`, 8: lines in the cache; must be a power of two.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_read`  in  1  CPU fetch request, level.
- `cpu_addr`  in  WORD_SIZE  fetch word address.
- `cpu_rdata`  out  WORD_SIZE  fetched instruction; valid only when `cpu_ready`=1, otherwise 0.
- `cpu_ready`  out  1  request satisfied this cycle (hit).
- `flush`  in  1  invalidate all lines.
- `mem_read`  out  1  line fetch request, held high until `mem_valid`.
- `mem_addr`  out  WORD_SIZE  line base address; offset bits are zero.
- `mem_rdata`  in  WORD_SIZE*LINE_WORDS  full line; word 0 is in the LSBs.
- `mem_valid`  in  1  `mem_rdata` valid; a one-cycle pulse while `mem_read`=1.
- `hit_count`  out  WORD_SIZE  number of hits, wraps on overflow.
- `miss_count`  out  WORD_SIZE  number of misses, wraps on overflow.

## Operation
- Address split, for the defaults: offset `[1:0]`, index `[4:2]`, tag `[15:5]`. In general the field widths are log2(LINE_WORDS), log2(NUM_LINES), and the remainder.
- Per-line storage: valid bit, tag, and LINE_WORDS data words.
- FSM has two states:
  - IDLE: if `cpu_read` and valid[index] and tag match, the access is a hit: `cpu_ready`=1 and `cpu_rdata`=the selected word. If `cpu_read` and not a hit, latch the line address and go to FETCH.
  - FETCH: `mem_read`=1 and `mem_addr`=the latched line address. On `mem_valid`, write the data, set valid, and write the tag at the latched index, then return to IDLE.
- In FETCH `cpu_ready`=0 regardless of the inputs.
- The counters increment by 1:
  - `hit_count` on each IDLE cycle with a hit.
  - `miss_count` on each IDLE→FETCH transition.
  - Both wrap from 0xFFFF to 0x0000.

Boundary conditions:
- `cpu_read` drops or `cpu_addr` changes during FETCH: the fill completes for the latched line. The new address is evaluated in IDLE afterwards.
- `flush` in any state clears all valid bits at that edge. `flush` coincident with the `mem_valid` edge: the data is written but valid stays 0. FETCH is not aborted.
- `flush` with `cpu_read` in IDLE: the lookup in that cycle uses the pre-flush valid bits, so a hit is still reported.
- `mem_valid` outside FETCH: ignored.
- `reset` (including mid-FETCH): state→IDLE, all valid bits 0, `mem_read`=0 immediately, counters 0. Data and tag arrays need not be reset.
- Reset values: `cpu_ready`=0, `cpu_rdata`=0, `mem_read`=0, `mem_addr`=0, `hit_count`=0, `miss_count`=0.

## Timing
- Hit: 0-cycle latency; `cpu_ready` is combinational from `cpu_addr`, `cpu_read`, and registered state.
- Miss at cycle t:
  - t+1: FETCH begins and `mem_read` rises.
  - Memory asserts `mem_valid` at cycle t+L, with L≥1.
  - t+L+1: IDLE, and the retried request hits.
  - Total stall: L+1 cycles.
- `mem_addr` is registered and stable throughout FETCH.
- There is no combinational path from `mem_rdata` to `cpu_rdata`.

## Structure
- Shared package holds the FSM state encoding (IDLE, FETCH), `WORD_SIZE`, and the derived offset/index/tag widths as functions of the parameters.
- One sub-module, `icache_array`, holds the valid, tag, and data storage. It has one combinational read port (index → valid, tag, line), one synchronous write port, and a synchronous clear-all input.
- The top level holds the FSM, hit compare, word select, and counters.

## Test plan
Memory model used throughout: latency L=3.
1. Cold miss: after reset, read 0x0012. Expect `mem_read` at t+1 with `mem_addr`=0x0010, `mem_valid` at t+3, `cpu_ready` at t+4 with word 2 of the line. `miss_count`=1, `hit_count`=1.
2. Spatial hits: after scenario 1, read 0x0010, 0x0011, 0x0013 on consecutive cycles. Expect `cpu_ready`=1 on each with the matching words, `hit_count`=4, no `mem_read`.
3. Conflict: read 0x0020 and 0x0000, which share index 0 and have different tags. Expect each access to miss and refill, with `miss_count` incrementing per access and the line contents alternating.
4. Address change mid-fetch: miss on 0x0040, switch `cpu_addr` to 0x0010 during FETCH. Expect the line at 0x0040 filled, then 0x0010 to hit if it is still cached (different index), with no second `mem_read`.
5. Flush on the fill edge: assert `flush` on the `mem_valid` cycle. Expect the next access to the same address to miss again, and all lines invalid.
6. Reset mid-FETCH: assert `reset` one cycle after `mem_read` rises. Expect `mem_read`=0 asynchronously, counters 0, and a later `mem_valid` ignored.
